// File: rtl/pq_arb_if.sv
// ----------------------------------------------------------------------------
// pq_pkg / pq_arb_if : HWPQ pair type, and the client plus HWPQ bus of pq_arb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pq_pkg;
    typedef struct packed {
        logic [3:0] key;
        logic [3:0] val;
    } kv_t;

    localparam int  PQ_CAPACITY = 16;
    localparam kv_t KV_EMPTY    = '{key: 4'hF, val: 4'h0};
endpackage

interface pq_arb_if #(
    parameter int NREQ = 4
);
    localparam int KVW = $bits(pq_pkg::kv_t);

    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_op;
    logic [NREQ*KVW-1:0] req_kv;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [KVW-1:0]      rsp_kv;
    logic                rsp_err;
    logic                pq_enq;
    logic                pq_deq;
    logic [KVW-1:0]      pq_kv_in;
    logic                pq_busy;
    logic                pq_ack;
    logic [KVW-1:0]      pq_kv_out;
    logic                pq_full;
    logic                pq_empty;

    modport slave (
        input  req, req_op, req_kv, pq_busy, pq_ack, pq_kv_out, pq_full, pq_empty,
        output gnt, done, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kv_in
    );

    modport master (
        output req, req_op, req_kv, pq_busy, pq_ack, pq_kv_out, pq_full, pq_empty,
        input  gnt, done, rsp_kv, rsp_err, pq_enq, pq_deq, pq_kv_in
    );
endinterface

`default_nettype wire

// File: rtl/pq_arb.sv
// ----------------------------------------------------------------------------
// pq_arb : round-robin front end sharing one hardware priority queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pq_arb #(
    parameter int NREQ = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    pq_arb_if.slave   bus
);
    import pq_pkg::*;

    localparam int KVW = $bits(kv_t);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, win_q, win_d;
    logic            op_q, op_d, err_q, err_d;
    kv_t             kv_q, kv_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            enq_q, enq_d, deq_q, deq_d;
    kv_t             kv_in_q, kv_in_d, rsp_kv_q, rsp_kv_d;
    logic            rsp_err_q, rsp_err_d;

    logic [IW-1:0]   base;
    logic [IW-1:0]   pick;
    logic            any;
    int              j;

    function automatic logic [IW-1:0] inc_w(input logic [IW-1:0] w);
        return (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
    endfunction

    // RESP arbitrates too, so a new grant can follow done by one cycle
    always_comb begin
        base = (state_q == S_RESP) ? inc_w(win_q) : rr_q;
        any  = 1'b0;
        pick = '0;
        j    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(base) + k) % NREQ;
            if (bus.req[j]) begin
                any  = 1'b1;
                pick = IW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        op_d      = op_q;
        err_d     = err_q;
        kv_d      = kv_q;
        gnt_d     = '0;
        done_d    = '0;
        enq_d     = 1'b0;
        deq_d     = 1'b0;
        kv_in_d   = kv_in_q;
        rsp_kv_d  = rsp_kv_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (state_q == S_RESP) begin
                    rr_d = inc_w(win_q);
                end
                state_d = S_IDLE;
                if (any) begin
                    gnt_d[pick] = 1'b1;
                    win_d       = pick;
                    op_d        = bus.req_op[pick];
                    kv_d        = bus.req_kv[int'(pick)*KVW +: KVW];
                    err_d       = bus.req_op[pick] ? bus.pq_empty : bus.pq_full;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A rejected request passes through here without touching the HWPQ
                if (err_q) begin
                    done_d[win_q] = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_kv_d      = KV_EMPTY;
                    state_d       = S_RESP;
                end else if (!bus.pq_busy) begin
                    enq_d   = ~op_q;
                    deq_d   = op_q;
                    if (!op_q) begin
                        kv_in_d = kv_q;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.pq_ack) begin
                    done_d[win_q] = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_kv_d      = op_q ? kv_t'(bus.pq_kv_out) : KV_EMPTY;
                    state_d       = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            op_q      <= 1'b0;
            err_q     <= 1'b0;
            kv_q      <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            enq_q     <= 1'b0;
            deq_q     <= 1'b0;
            kv_in_q   <= '0;
            rsp_kv_q  <= KV_EMPTY;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            op_q      <= op_d;
            err_q     <= err_d;
            kv_q      <= kv_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            enq_q     <= enq_d;
            deq_q     <= deq_d;
            kv_in_q   <= kv_in_d;
            rsp_kv_q  <= rsp_kv_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.pq_enq   = enq_q;
    assign bus.pq_deq   = deq_q;
    assign bus.pq_kv_in = kv_in_q;
    assign bus.rsp_kv   = rsp_kv_q;
    assign bus.rsp_err  = rsp_err_q;

endmodule

`default_nettype wire
